// File: rtl/itoa_pkg.sv
// Shared definitions for the Forth number-output converter (itoa).
// Holds the controller state encoding, the digit-count derivations used
// to size the BCD register and length counter, the ASCII constants and
// the digit-to-character helper.
package itoa_pkg;

    typedef enum logic [2:0] {IT0, SGN, CNV, SKP, EMT, DON} itoa_sts;

    // Decimal digits needed for an unsigned value of dsz bits.
    function automatic int itoa_nd(input int dsz);
        return (dsz * 3 + 9) / 10;
    endfunction

    // Length counter width: room for all digits plus a sign.
    function automatic int itoa_lsz(input int dsz);
        return $clog2(itoa_nd(dsz) + 2);
    endfunction

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_MINUS = 8'h2D;

    // One nibble to its uppercase hex / decimal character.
    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        if (d < 4'd10) return CH_0 + {4'd0, d};
        else           return CH_A + {4'd0, d} - 8'd10;
    endfunction

endpackage

// File: rtl/itoa_bcd_adj.sv
// Double-dabble correction step: every BCD digit that is 5 or more gets
// 3 added, so the following left shift carries correctly into the next
// decade. Purely combinational.
//   bcd_i : ND packed BCD digits before the shift
//   bcd_o : corrected digits, ready to be shifted left by one bit
module bcd_adj #(
    parameter int ND = 10
) (
    input  logic [4*ND-1:0] bcd_i,
    output logic [4*ND-1:0] bcd_o
);

    always_comb begin
        bcd_o = bcd_i;
        for (int k = 0; k < ND; k++) begin
            if (bcd_i[4*k +: 4] >= 4'd5)
                bcd_o[4*k +: 4] = bcd_i[4*k +: 4] + 4'd3;
        end
    end

endmodule

// File: rtl/itoa.sv
// Sequential integer-to-ASCII converter. Converts a DSZ-bit value into
// text (signed decimal or unsigned uppercase hex), most significant digit
// first, and writes it byte by byte to consecutive addresses from pad.
//   clk, rst : clock, synchronous active-high reset
//   en       : level enable; starts a run from idle, aborts when low
//   hex      : 0 signed decimal, 1 unsigned hex
//   vi, pad  : value and first byte address, sampled on the start edge
//   bsy      : conversion in progress
//   we/ao/dout : registered byte write strobe, address, data
//   len      : bytes written in the last completed run
module itoa
    import itoa_pkg::*;
#(
    parameter  int ASZ = 17,
    parameter  int DSZ = 32,
    localparam int ND  = itoa_nd(DSZ),
    localparam int LSZ = itoa_lsz(DSZ)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           hex,
    input  logic [DSZ-1:0] vi,
    input  logic [ASZ-1:0] pad,
    output logic           bsy,
    output logic           we,
    output logic [ASZ-1:0] ao,
    output logic [7:0]     dout,
    output logic [LSZ-1:0] len
);

    localparam int BW = 4 * ND;
    localparam int CW = $clog2(DSZ + 1);
    localparam int RW = $clog2(ND + 1);

    itoa_sts        state_q, state_d;
    logic           bsy_q, bsy_d;
    logic           we_q, we_d;
    logic [ASZ-1:0] ao_q, ao_d;
    logic [7:0]     dout_q, dout_d;
    logic [LSZ-1:0] len_q, len_d;

    logic           hex_q, hex_d;
    logic           neg_q, neg_d;
    logic [DSZ-1:0] mag_q, mag_d;
    logic [BW-1:0]  dig_q, dig_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]  rem_q, rem_d;
    logic [ASZ-1:0] p_q, p_d;

    logic [BW-1:0]  adj;
    logic [3:0]     top;
    logic           neg_in;
    logic           skip;
    logic           emit;
    logic           running;

    bcd_adj #(.ND(ND)) u_adj (
        .bcd_i (dig_q),
        .bcd_o (adj)
    );

    assign top     = dig_q[BW-1 -: 4];
    assign neg_in  = !hex && vi[DSZ-1];
    // Leading zeros are dropped, but the last digit is always printed.
    assign skip    = (top == 4'd0) && (rem_q > RW'(1));
    // SKP falls straight into emitting the first significant digit so the
    // total of skip + emit cycles equals the digit count.
    assign emit    = (state_q == EMT) || ((state_q == SKP) && !skip);
    assign running = (state_q != IT0) && (state_q != DON);

    assign bsy  = bsy_q;
    assign we   = we_q;
    assign ao   = ao_q;
    assign dout = dout_q;
    assign len  = len_q;

    // State register and reset-visible outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IT0;
            bsy_q   <= 1'b0;
            we_q    <= 1'b0;
            ao_q    <= '0;
            dout_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            bsy_q   <= bsy_d;
            we_q    <= we_d;
            ao_q    <= ao_d;
            dout_q  <= dout_d;
            len_q   <= len_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IT0: if (en) state_d = SGN;
            SGN: state_d = hex_q ? SKP : CNV;
            CNV: if (cnt_q == CW'(1)) state_d = SKP;
            SKP: if (!skip) state_d = (rem_q == RW'(1)) ? DON : EMT;
            EMT: if (rem_q == RW'(1)) state_d = DON;
            DON: if (!en) state_d = IT0;
            default: state_d = IT0;
        endcase
        if (running && !en) state_d = IT0;
    end

    // Output and datapath next values
    always_comb begin
        bsy_d  = bsy_q;
        we_d   = 1'b0;
        ao_d   = ao_q;
        dout_d = dout_q;
        len_d  = len_q;
        hex_d  = hex_q;
        neg_d  = neg_q;
        mag_d  = mag_q;
        dig_d  = dig_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        p_d    = p_q;

        unique case (state_q)
            IT0: begin
                if (en) begin
                    hex_d = hex;
                    neg_d = neg_in;
                    mag_d = neg_in ? -vi : vi;
                    p_d   = pad;
                    bsy_d = 1'b1;
                    len_d = '0;
                end
            end
            SGN: begin
                if (neg_q) begin
                    we_d   = 1'b1;
                    ao_d   = p_q;
                    dout_d = CH_MINUS;
                    p_d    = p_q + ASZ'(1);
                    len_d  = len_q + LSZ'(1);
                end
                if (hex_q) begin
                    dig_d = BW'(mag_q) << (BW - DSZ);
                    rem_d = RW'(DSZ / 4);
                end else begin
                    dig_d = '0;
                    cnt_d = CW'(DSZ);
                end
            end
            CNV: begin
                {dig_d, mag_d} = {adj, mag_q} << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) rem_d = RW'(ND);
            end
            SKP: begin
                if (skip) begin
                    dig_d = dig_q << 4;
                    rem_d = rem_q - RW'(1);
                end
            end
            default: ;
        endcase

        if (emit) begin
            we_d   = 1'b1;
            ao_d   = p_q;
            dout_d = digit_ascii(top);
            dig_d  = dig_q << 4;
            rem_d  = rem_q - RW'(1);
            p_d    = p_q + ASZ'(1);
            len_d  = len_q + LSZ'(1);
            if (rem_q == RW'(1)) bsy_d = 1'b0;
        end

        // Dropping en mid-run abandons the conversion without a write.
        if (running && !en) begin
            bsy_d = 1'b0;
            we_d  = 1'b0;
            len_d = '0;
        end
    end

    // Datapath registers (no reset: only meaningful during a run)
    always_ff @(posedge clk) begin
        hex_q <= hex_d;
        neg_q <= neg_d;
        mag_q <= mag_d;
        dig_q <= dig_d;
        cnt_q <= cnt_d;
        rem_q <= rem_d;
        p_q   <= p_d;
    end

endmodule

// File: tb/tb_itoa.sv
module tb_itoa;

    localparam int ASZ = 17;
    localparam int DSZ = 32;
    localparam int ND  = (DSZ * 3 + 9) / 10;
    localparam int LSZ = $clog2(ND + 2);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en  = 1'b0;
    logic           hex = 1'b0;
    logic [DSZ-1:0] vi  = '0;
    logic [ASZ-1:0] pad = '0;
    logic           bsy;
    logic           we;
    logic [ASZ-1:0] ao;
    logic [7:0]     dout;
    logic [LSZ-1:0] len;

    int checks = 0;
    int errors = 0;

    logic [7:0]     exp_q[$];
    logic [7:0]     got_d[$];
    logic [ASZ-1:0] got_a[$];
    int             got_e[$];

    itoa #(.ASZ(ASZ), .DSZ(DSZ)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .hex  (hex),
        .vi   (vi),
        .pad  (pad),
        .bsy  (bsy),
        .we   (we),
        .ao   (ao),
        .dout (dout),
        .len  (len)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference text: the number printed with ordinary division.
    task automatic model(input logic [31:0] v, input logic h);
        longint unsigned m;
        int d;
        bit ng;
        exp_q.delete();
        ng = !h && v[31];
        m  = ng ? (64'd4294967296 - {32'd0, v}) : {32'd0, v};
        if (h) begin
            do begin
                d = int'(m % 16);
                exp_q.push_front(d < 10 ? 8'(48 + d) : 8'(55 + d));
                m = m / 16;
            end while (m != 0);
        end else begin
            do begin
                d = int'(m % 10);
                exp_q.push_front(8'(48 + d));
                m = m / 10;
            end while (m != 0);
        end
        if (ng) exp_q.push_front(8'h2D);
    endtask

    // Called at a negedge; runs one full conversion and checks it.
    task automatic convert(input string tag, input logic [31:0] v, input logic h,
                           input logic [ASZ-1:0] pd);
        int n;
        int lat;
        logic [ASZ-1:0] ea;
        model(v, h);
        got_d.delete();
        got_a.delete();
        got_e.delete();
        vi  = v;
        hex = h;
        pad = pd;
        en  = 1'b1;
        @(posedge clk);
        // Inputs other than en must not matter after the start edge.
        #1;
        vi  = $urandom;
        pad = ASZ'($urandom);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (we) begin
                got_d.push_back(dout);
                got_a.push_back(ao);
                got_e.push_back(n);
            end
            if (!bsy) break;
            @(posedge clk);
            n++;
        end
        lat = h ? (DSZ / 4 + 1) : (DSZ + ND + 1);
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_last_we"}, we, 1'b1);
        chk({tag, "_len"}, len, exp_q.size());
        chk({tag, "_nbytes"}, got_d.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_d.size()) begin
                ea = pd + ASZ'(i);
                chk($sformatf("%s_byte%0d", tag, i), got_d[i], exp_q[i]);
                chk($sformatf("%s_addr%0d", tag, i), got_a[i], ea);
            end
        end
        if (!h && v[31] && got_e.size() > 0)
            chk({tag, "_sign_edge"}, got_e[0], 1);
        en = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_bsy"}, bsy, 1'b0);
        chk({tag, "_idle_we"}, we, 1'b0);
        chk({tag, "_len_hold"}, len, exp_q.size());
    endtask

    initial begin
        int nw;
        int k;
        int r;
        logic [31:0] rv;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bsy", bsy, 1'b0);
        chk("rst_we", we, 1'b0);
        chk("rst_ao", ao, '0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_len", len, '0);
        rst = 1'b0;
        @(negedge clk);

        // Directed conversions
        convert("dec1234", 32'd1234, 1'b0, 17'h100);
        convert("decmin", 32'h8000_0000, 1'b0, 17'h100);
        convert("dec0", 32'd0, 1'b0, 17'h180);
        convert("hex0", 32'd0, 1'b1, 17'h1C0);
        convert("hexdead", 32'hDEAD_BEEF, 1'b1, 17'h200);
        convert("hexff", 32'hFFFF_FFFF, 1'b1, 17'h240);
        convert("hexa0", 32'h0000_00A0, 1'b1, 17'h280);
        convert("decmax", 32'h7FFF_FFFF, 1'b0, 17'h2C0);
        convert("decm1", 32'hFFFF_FFFF, 1'b0, 17'h300);
        convert("wrap", 32'h0000_1234, 1'b1, 17'h1FFFE);

        // Back-to-back with a single low cycle between
        convert("b2b99", 32'd99, 1'b0, 17'h400);
        convert("b2bm5", -32'sd5, 1'b0, 17'h400);

        // en dropped mid-CNV
        vi = 32'd1234; hex = 1'b0; pad = 17'h040; en = 1'b1;
        nw = 0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (we) nw++;
        end
        en = 1'b0;
        @(negedge clk);
        chk("abort_bsy", bsy, 1'b0);
        chk("abort_we", we, 1'b0);
        chk("abort_len", len, '0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (we) nw++;
        end
        chk("abort_nowrites", nw, 0);

        // Reset pulsed during emission, with en still high
        vi = 32'd1234; hex = 1'b0; pad = 17'h0AA; en = 1'b1;
        k = 0;
        @(negedge clk);
        while (!we && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("emt_reached", we, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_bsy", bsy, 1'b0);
        chk("rstmid_we", we, 1'b0);
        chk("rstmid_ao", ao, '0);
        chk("rstmid_dout", dout, 8'h00);
        chk("rstmid_len", len, '0);
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
        chk("rstmid_idle_bsy", bsy, 1'b0);
        chk("rstmid_idle_we", we, 1'b0);

        convert("re7", 32'd7, 1'b0, 17'h500);

        // Randomized conversions
        for (int it = 0; it < 25; it++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0)      rv = 32'($urandom_range(0, 200));
            else if (r == 1) rv = -32'($urandom_range(1, 200));
            else             rv = $urandom;
            convert($sformatf("rnd%0d", it), rv, 1'($urandom_range(0, 1)), ASZ'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/itoa.md
# itoa

Sequential integer-to-ASCII converter for the Forth number-output path (`.`, `U.`, `.HEX`). It is the output-direction counterpart of the atoi parser. The block takes a DSZ-bit value and writes its text, most significant digit first, as a byte stream into the pad buffer over a byte-wide memory write port. It returns the character count so the outer interpreter can `TYPE` the pad.

## Interface
- `ASZ`, 17, byte address width
- `DSZ`, 32, value width; localparam `ND = (DSZ*3+9)/10` gives the number of decimal digits (10 for 32-bit); localparam `LSZ = $clog2(ND+2)`
- `clk`  in  1  clock; only clock
- `rst`  in  1  reset; synchronous, active-high
- `en`  in  1  level enable; rising sample starts a conversion; low aborts and returns to idle
- `hex`  in  1  0: signed decimal, 1: unsigned hex (uppercase, no sign)
- `vi`  in  DSZ  value to convert; sampled only on the start edge
- `pad`  in  ASZ  first output byte address; sampled on the start edge
- `bsy`  out  1  1: conversion in progress
- `we`  out  1  write strobe; one cycle per byte
- `ao`  out  ASZ  write address
- `dout`  out  8  ASCII byte
- `len`  out  LSZ  bytes written; valid when `bsy`=0 after a completed run

## Operation
- States: IT0 (idle), SGN, CNV, SKP, EMT, DON.
- **IT0:** on a clock edge with `en`=1:
  - latch `neg = !hex && vi[DSZ-1]`;
  - latch `mag = neg ? -vi : vi`, unsigned DSZ bits, so -2^(DSZ-1) is representable;
  - set pointer `p = pad`, `bsy <= 1`, `len <= 0`, go to SGN.
- **SGN:**
  - If `neg`: write `"-"` at `p`, increment `p` and `len`.
  - Decimal: clear the BCD register (4*ND bits), load the shift counter with DSZ, go to CNV.
  - Hex: load `mag` left-aligned into the digit register, set remaining = DSZ/4, go to SKP.
- **CNV** (double-dabble, one bit per cycle, DSZ cycles):
  - Add 3 to every BCD digit that is ≥5.
  - Shift {BCD, mag} left by 1.
  - When done, set remaining = ND and go to SKP.
- **SKP:** while the top digit is 0 and remaining > 1, shift the digit register left 4 and decrement remaining, one digit per cycle. Otherwise go to EMT (no cycle spent if nothing to skip).
- **EMT:**
  - Write `ascii(top digit)`: `"0"+d` for d<10, `"A"+d-10` otherwise.
  - Shift left 4, decrement remaining, increment `p` and `len`.
  - When remaining reaches 0, go to DON with `bsy <= 0`.
- **DON:** hold `len`, `bsy`=0, `we`=0 until `en` falls, then go to IT0. A new conversion requires an `en` low→high transition.
- **Writes:** registered. The edge that processes a write sets `we <= 1`, `ao <= p`, `dout <= char`. In every other cycle `we <= 0`. `ao` and `dout` hold their last values.
- **Value 0:** prints `"0"`. SKP always leaves at least one digit.

## Timing
- **Reset values:** `bsy`=0, `we`=0, `ao`=0, `dout`=0, `len`=0, state IT0.
- **Start:** `en` is sampled high at edge E0; `bsy`=1 after E0.
- **Latency is value-independent**, because skip cycles plus emit cycles always total the digit count:
  - decimal: last `we` and `bsy`=0 both appear after edge E0+DSZ+ND+1 (43 for DSZ=32);
  - hex: after edge E0+DSZ/4+1 (9).
- **Last byte:** the final write strobe is coincident with `bsy` falling; consumers sample `we` in that cycle.
- **Address sequence:** strictly `pad`, `pad+1`, …, with no gaps. `ao` wraps modulo 2^ASZ.
- **`en` low mid-run:** next edge goes to IT0 with `bsy`=0, `we`=0, `len`=0; no further writes.
- **`rst` mid-run:** same effect as `en` low, plus the output reset values above. `rst` overrides `en` on the same edge.

## Structure
- The shared forthsuper package holds:
  - `typedef enum logic [2:0] {IT0, SGN, CNV, SKP, EMT, DON} itoa_sts`;
  - the ND/LSZ derivation;
  - the ASCII constants `"0"`, `"A"`, `"-"`.
- Sub-module `bcd_adj`: combinational add-3-if-≥5 across ND digits, one double-dabble step. The rest is a single 4-block FSM: state register, next-state logic, output logic, datapath register.
- A bus-master wrapper `itoaer` maps `we`/`ao`/`dout` onto the shared mb8 bus and lives alongside this block.

## Test plan
- Decimal 1234, `pad`=0x100 → writes `"1","2","3","4"` at 0x100–0x103, `len`=4, `bsy` falls at E0+43.
- Decimal -2147483648 → `"-2147483648"` at 0x100–0x10A, `len`=11, `bsy` falls at E0+43, `"-"` strobed after E1.
- Decimal 0 → single `"0"` at `pad`, `len`=1; hex 0 → `"0"`, `len`=1, `bsy` falls at E0+9.
- Hex 0xDEADBEEF → `"DEADBEEF"`, `len`=8; hex 0xFFFFFFFF → `"FFFFFFFF"` with no sign; hex 0x00000A0 → `"A0"`, `len`=2, `bsy` falls at E0+9.
- Interruptions:
  - `en` dropped at E0+10 (mid-CNV) → `we`=0 from the next edge, no writes, `bsy`=0.
  - `rst` pulsed during EMT → all outputs at reset values.
  - Re-enable with 7 → `"7"`, `len`=1.
- Back-to-back: 99 then -5 with `en` toggled low for one cycle between → `"99"` then `"-5"`; `len` updates and no stale bytes are written.
